// File: rtl/lab_readout_pkg.sv
// Shared definitions for the LAB sample RAM readout: default sizes,
// header magic, FSM state encoding and the header word builder.
package lab_readout_pkg;

  localparam int unsigned NUM_WORDS_DEF = 1170;
  localparam int unsigned ADDR_W_DEF    = 11;
  localparam logic [15:0] HDR_MAGIC_DEF = 16'hEB90;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HDR   = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } rd_state_t;

  function automatic logic [31:0] make_header(input logic [15:0] magic,
                                              input logic [15:0] evt);
    return {magic, evt};
  endfunction

endpackage

// File: rtl/lab_readout_skid2.sv
// Two-entry FIFO carrying {last, data}. Entry e0 is always the head, so
// the head output comes straight from a register and stays put while
// the consumer stalls. Pushing into a full FIFO without a pop is not
// expected; the caller's issue rule keeps occupancy at or below two.
module lab_readout_skid2 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic [32:0] push_dat_i,
  input  logic        pop_i,
  output logic [32:0] head_o,
  output logic [1:0]  occ_o
);

  logic [32:0] e0_q;
  logic [32:0] e1_q;
  logic [1:0]  occ_q;
  logic        pop_eff;

  assign pop_eff = pop_i && (occ_q != 2'd0);
  assign head_o  = e0_q;
  assign occ_o   = occ_q;

  // Storage shift and occupancy update for push / pop / both.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      case ({push_i, pop_eff})
        2'b10: begin
          if (occ_q == 2'd0) begin
            e0_q  <= push_dat_i;
            occ_q <= 2'd1;
          end else if (occ_q == 2'd1) begin
            e1_q  <= push_dat_i;
            occ_q <= 2'd2;
          end
        end
        2'b01: begin
          e0_q  <= e1_q;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            e0_q <= push_dat_i;
          end else begin
            e0_q <= e1_q;
            e1_q <= push_dat_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/lab_ram_readout.sv
// Reads one stored event out of the LAB sample RAM and streams it as a
// header word followed by NUM_WORDS data words.
// Handshake: a word transfers on a rising clk_i edge where valid_o && ready_i;
// dat_o/last_o hold while valid_o && !ready_i; valid_o never drops without a
// transfer except on reset.
// The RAM read address is presented combinationally in the issue cycle so
// the synchronous RAM returns data in the next cycle, where it is pushed.
// The first read is issued alongside the header push so the header and the
// data words leave back to back. state_o exposes the FSM for debug.
module lab_ram_readout
  import lab_readout_pkg::*;
#(
  parameter int unsigned NUM_WORDS = NUM_WORDS_DEF,
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter logic [15:0] HDR_MAGIC = HDR_MAGIC_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] raddr_o,
  input  logic [31:0]       ram_dat_i,
  output logic [31:0]       dat_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic [15:0]       evt_cnt_o,
  output rd_state_t         state_o
);

  localparam logic [ADDR_W-1:0] N_WORDS   = ADDR_W'(NUM_WORDS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_WORDS - 1);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] issued_q;
  logic [ADDR_W-1:0] raddr_q;
  logic              inflight_q;
  logic              rd_last_q;
  logic              done_q;
  logic [15:0]       evt_q;

  logic [32:0]       head;
  logic [1:0]        occ;
  logic              pop;
  logic              push;
  logic [32:0]       push_dat;
  logic              hdr_push;
  logic [2:0]        occ_after_pop;
  logic [2:0]        load;
  logic              issue;
  logic              start_ok;
  logic              finish;

  assign valid_o   = (occ != 2'd0);
  assign pop       = valid_o && ready_i;
  assign hdr_push  = (state_q == ST_HDR);
  assign start_ok  = start_i && (state_q == ST_IDLE) && !done_q;
  assign finish    = (state_q == ST_DRAIN) && pop && head[32];

  // Words that will sit in the buffer next cycle if nothing else is issued.
  assign occ_after_pop = {1'b0, occ} - {2'b00, pop};
  assign load          = occ_after_pop + {2'b00, inflight_q} + {2'b00, hdr_push};
  assign issue         = ((state_q == ST_HDR) || (state_q == ST_READ)) &&
                         (issued_q < N_WORDS) && (load <= 3'd1);

  assign raddr_o   = issue ? issued_q : raddr_q;
  assign push      = hdr_push || inflight_q;
  assign push_dat  = hdr_push ? {1'b0, make_header(HDR_MAGIC, evt_q)}
                              : {rd_last_q, ram_dat_i};

  assign dat_o     = head[31:0];
  assign last_o    = head[32];
  assign busy_o    = (state_q != ST_IDLE);
  assign done_o    = done_q;
  assign evt_cnt_o = evt_q;
  assign state_o   = state_q;

  lab_readout_skid2 u_buf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .head_o     (head),
    .occ_o      (occ)
  );

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state: header, reads, then wait for the last word to leave.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_HDR;
      ST_HDR:   state_d = ST_READ;
      ST_READ:  if (issued_q == N_WORDS) state_d = ST_DRAIN;
      ST_DRAIN: if (finish) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Read pipeline, done pulse and event counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      issued_q   <= '0;
      raddr_q    <= '0;
      inflight_q <= 1'b0;
      rd_last_q  <= 1'b0;
      done_q     <= 1'b0;
      evt_q      <= 16'd0;
    end else begin
      raddr_q    <= raddr_o;
      inflight_q <= issue;
      rd_last_q  <= issue && (issued_q == LAST_ADDR);
      done_q     <= finish;
      if (start_ok)   issued_q <= '0;
      else if (issue) issued_q <= issued_q + ADDR_W'(1);
      if (finish)     evt_q <= evt_q + 16'd1;
    end
  end

endmodule
